// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters/UART transmitter and uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   ack;
    logic              newd;
    logic [7:0]        dintx;
    logic              donetx;
    logic              busy;
    logic [2:0]        gnt_id;
    logic              timeout_err;

    modport slave (
        input  req, din, donetx,
        output ack, newd, dintx, busy, gnt_id, timeout_err
    );

    modport master (
        output req, din, donetx,
        input  ack, newd, dintx, busy, gnt_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NREQ requesters into a single UART transmitter.
// Optional WAIT_DONE watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int NEWD_HOLD = 128,
    parameter int TIMEOUT   = 4096
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    // state     | meaning
    // IDLE      | arbitrate among pending requests
    // ISSUE     | newd high, dintx held, hold timer running
    // WAIT_DONE | wait for a fresh synchronized donetx rising edge
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int HW = $clog2(NEWD_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(NEWD_HOLD - 1);

    logic [1:0]      state_q, state_d;
    logic [7:0]      dintx_q, dintx_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic [2:0]      last_gnt_q, last_gnt_d;
    logic            newd_q, newd_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            sync1_q, sync2_q, done_prev_q;
    logic            done_rise;
    logic            arb_hold;
    logic [2:0]      winner;
    logic            found;
    int              idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    assign arb_hold = (|ack_q) | timeout_err_q;
`else
    assign arb_hold = |ack_q;
`endif

    assign done_rise = sync2_q & ~done_prev_q;

    always_comb begin
        found  = 1'b0;
        winner = last_gnt_q;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dintx_d    = dintx_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        newd_d     = newd_q;
        ack_d      = '0;
        hold_d     = hold_q;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // The ack/timeout cycle is skipped so a requester can drop req after seeing ack.
                if (found && !arb_hold) begin
                    state_d  = S_ISSUE;
                    dintx_d  = bus.din[8*int'(winner) +: 8];
                    gnt_id_d = winner;
                    newd_d   = 1'b1;
                    hold_d   = HOLD_LOAD;
                end
            end
            S_ISSUE: begin
                if (hold_q == '0) begin
                    newd_d  = 1'b0;
                    state_d = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_d = TO_LOAD;
`endif
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    ack_d      = NREQ'(1) << gnt_id_q;
                    last_gnt_d = gnt_id_q;
                    state_d    = S_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt_q == '0) begin
                    timeout_err_d = 1'b1;
                    last_gnt_d    = gnt_id_q;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                newd_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dintx_q     <= 8'h00;
            gnt_id_q    <= 3'd0;
            last_gnt_q  <= 3'(NREQ - 1);
            newd_q      <= 1'b0;
            ack_q       <= '0;
            hold_q      <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dintx_q     <= dintx_d;
            gnt_id_q    <= gnt_id_d;
            last_gnt_q  <= last_gnt_d;
            newd_q      <= newd_d;
            ack_q       <= ack_d;
            hold_q      <= hold_d;
            sync1_q     <= bus.donetx;
            sync2_q     <= sync1_q;
            done_prev_q <= sync2_q;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ack    = ack_q;
    assign bus.newd   = newd_q;
    assign bus.dintx  = dintx_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.gnt_id = gnt_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; expected values are hand-derived.
// Builds with or without UART_ARB_TIMEOUT_EN (TIMEOUT=16 when the watchdog is enabled).
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int NEWD_HOLD = 128;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .NEWD_HOLD(NEWD_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_newd(input logic level, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (bus.newd === level) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (bus.newd === level) ok = 1'b1;
    endtask

    // Rising donetx; the registered ack is visible three samples later.
    task automatic pulse_done(output logic [NREQ-1:0] ack_seen);
        bus.donetx = 1'b1;
        tick();
        tick();
        tick();
        ack_seen = bus.ack;
        bus.donetx = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.din = 32'hDEADBEEF;
        bus.donetx = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.newd !== 1'b0) begin n_err++; $display("FAIL reset_newd got %b want 0", bus.newd); end
        n_cmp++; if (bus.dintx !== 8'h00) begin n_err++; $display("FAIL reset_dintx got %h want 00", bus.dintx); end
        n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_gnt_id got %0d want 0", bus.gnt_id); end
        n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got %b want 0", bus.timeout_err); end
        rst = 1'b1;
        bus.req = '0;
        bus.donetx = 1'b0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_single();
        int cnt;
        bit stable;
        bit ok;
        do_reset();
        bus.req = 4'b0010;
        bus.din = 32'h4433A511;
        tick();
        n_cmp++; if (bus.newd !== 1'b1) begin n_err++; $display("FAIL single_latency newd got %b want 1", bus.newd); end
        n_cmp++; if (bus.gnt_id !== 3'd1) begin n_err++; $display("FAIL single_gnt_id got %0d want 1", bus.gnt_id); end
        n_cmp++; if (bus.dintx !== 8'hA5) begin n_err++; $display("FAIL single_dintx got %h want a5", bus.dintx); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", bus.busy); end
        bus.req = 4'b0000;
        cnt = (bus.newd === 1'b1) ? 1 : 0;
        stable = 1'b1;
        for (int i = 0; i < 300 && bus.newd === 1'b1; i++) begin
            tick();
            if (bus.newd === 1'b1) begin
                cnt++;
                if (bus.dintx !== 8'hA5) stable = 1'b0;
            end
        end
        n_cmp++; if (cnt != NEWD_HOLD) begin n_err++; $display("FAIL single_newd_width got %0d want %0d", cnt, NEWD_HOLD); end
        n_cmp++; if (!stable) begin n_err++; $display("FAIL single_dintx_stable got changed want a5 throughout"); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ack !== 4'b0000 || bus.busy !== 1'b1) ok = 1'b0;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_wait_quiet got ack/busy change want ack=0 busy=1"); end
        bus.donetx = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_early got %b want 0000", bus.ack); end
        tick();
        n_cmp++; if (bus.ack !== 4'b0010) begin n_err++; $display("FAIL single_ack got %b want 0010", bus.ack); end
        bus.donetx = 1'b0;
        tick();
        n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_width got %b want 0000", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.dintx !== 8'hA5) begin n_err++; $display("FAIL single_dintx_hold got %h want a5", bus.dintx); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] a;
        bit ok;
        int exp;
        do_reset();
        bus.req = 4'b1111;
        bus.din = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            exp = i % 4;
            wait_newd(1'b1, 10, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL fair_grant_timeout round %0d got no newd want newd", i); end
            n_cmp++; if (bus.gnt_id !== 3'(exp)) begin n_err++; $display("FAIL fair_gnt round %0d got %0d want %0d", i, bus.gnt_id, exp); end
            n_cmp++; if (bus.dintx !== 8'(8'h11 * (exp + 1))) begin n_err++; $display("FAIL fair_dintx round %0d got %h want %h", i, bus.dintx, 8'(8'h11 * (exp + 1))); end
            wait_newd(1'b0, 200, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL fair_issue_timeout round %0d got newd stuck want 0", i); end
            tick();
            tick();
            pulse_done(a);
            n_cmp++; if (a !== 4'(1 << exp)) begin n_err++; $display("FAIL fair_ack round %0d got %b want %b", i, a, 4'(1 << exp)); end
            tick();
            n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL fair_ack_width round %0d got %b want 0000", i, bus.ack); end
        end
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_stale_done();
        logic [NREQ-1:0] a;
        bit ok;
        bit seen;
        do_reset();
        bus.donetx = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.req = 4'b0001;
        bus.din = 32'h0000005A;
        wait_newd(1'b1, 10, ok);
        wait_newd(1'b0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stale_issue got newd stuck want 0"); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ack !== 4'b0000) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL stale_no_ack got ack want none"); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL stale_busy got %b want 1", bus.busy); end
        bus.donetx = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        pulse_done(a);
        n_cmp++; if (a !== 4'b0001) begin n_err++; $display("FAIL stale_ack got %b want 0001", a); end
        bus.req = 4'b0010;
        tick();
        // A full done pulse entirely inside ISSUE must be ignored.
        wait_newd(1'b1, 10, ok);
        for (int k = 0; k < 5; k++) tick();
        bus.donetx = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.donetx = 1'b0;
        wait_newd(1'b0, 200, ok);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ack !== 4'b0000) seen = 1'b1;
        end
        n_cmp++; if (seen || bus.busy !== 1'b1) begin n_err++; $display("FAIL issue_edge_ignored got ack=%b busy=%b want no ack busy=1", seen, bus.busy); end
        pulse_done(a);
        n_cmp++; if (a !== 4'b0010) begin n_err++; $display("FAIL issue_edge_ack got %b want 0010", a); end
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] a;
        bit ok;
        bit seen;
        do_reset();
        bus.req = 4'b0001;
        bus.din = 32'h00CC00AA;
        wait_newd(1'b1, 10, ok);
        wait_newd(1'b0, 200, ok);
        tick();
        pulse_done(a);
        n_cmp++; if (a !== 4'b0001) begin n_err++; $display("FAIL rmid_first_ack got %b want 0001", a); end
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0101;
        wait_newd(1'b1, 10, ok);
        n_cmp++; if (bus.gnt_id !== 3'd2) begin n_err++; $display("FAIL rmid_rr_gnt got %0d want 2", bus.gnt_id); end
        wait_newd(1'b0, 200, ok);
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.newd !== 1'b0 || bus.ack !== 4'b0000) begin
            n_err++; $display("FAIL rmid_abort got busy=%b newd=%b ack=%b want 0 0 0000", bus.busy, bus.newd, bus.ack);
        end
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && bus.newd !== 1'b1; k++) begin
            tick();
            if (bus.ack !== 4'b0000) seen = 1'b1;
        end
        n_cmp++; if (bus.newd !== 1'b1 || seen) begin n_err++; $display("FAIL rmid_regrant got newd=%b ack_seen=%b want 1 0", bus.newd, seen); end
        n_cmp++; if (bus.gnt_id !== 3'd0 || bus.dintx !== 8'hAA) begin n_err++; $display("FAIL rmid_gnt0 got id=%0d dintx=%h want 0 aa", bus.gnt_id, bus.dintx); end
        bus.req = 4'b0000;
        do_reset();
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        bit bad_busy;
        do_reset();
        bus.donetx = 1'b0;
        bus.req = 4'b0001;
        bus.din = 32'h00007711;
        wait_newd(1'b1, 10, ok);
        wait_newd(1'b0, 200, ok);
`ifdef UART_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.timeout_err !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL tmo_early got pulse want none before 16"); end
        tick();
        n_cmp++; if (bus.timeout_err !== 1'b1 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL tmo_pulse got err=%b ack=%b busy=%b want 1 0000 0", bus.timeout_err, bus.ack, bus.busy);
        end
        bus.req = 4'b0011;
        tick();
        n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_width got %b want 0", bus.timeout_err); end
        wait_newd(1'b1, 10, ok);
        n_cmp++; if (!ok || bus.gnt_id !== 3'd1) begin n_err++; $display("FAIL tmo_next_gnt got ok=%b id=%0d want 1 1", ok, bus.gnt_id); end
`else
        seen = 1'b0;
        bad_busy = 1'b0;
        for (int k = 0; k < 4200; k++) begin
            tick();
            if (bus.timeout_err !== 1'b0) seen = 1'b1;
            if (bus.busy !== 1'b1) bad_busy = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL notmo_err got pulse want constant 0"); end
        n_cmp++; if (bad_busy) begin n_err++; $display("FAIL notmo_busy got drop want busy held 1"); end
`endif
        bus.req = 4'b0000;
        do_reset();
    endtask

    initial begin
        bus.req = '0;
        bus.din = '0;
        bus.donetx = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_stale_done();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NREQ, 4, number of requesters (2..8).
- NEWD_HOLD, 128, clk cycles newd is held high per byte; at least one full transmitter bit-clock period.
- TIMEOUT, 4096, clk cycles allowed in WAIT_DONE, used only with UART_ARB_TIMEOUT_EN.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req  in  NREQ  per-requester transmit request, level.
- din  in  8*NREQ  per-requester byte; requester i on bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse to requester i when its byte is sent.
- newd  out  1  new-data strobe to the UART transmitter.
- dintx  out  8  byte to the UART transmitter.
- donetx  in  1  transmitter done flag, level, asynchronous to arbitration.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  3  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE, WAIT_DONE.
REQ-004 IDLE with req != 0 SHALL grant round-robin: search starts at last_gnt+1 and wraps modulo NREQ. The same edge SHALL latch din of the winner into dintx, set gnt_id, and enter ISSUE.
REQ-005 Latency SHALL be exactly one cycle: req seen in IDLE at edge N gives newd=1 after edge N.
REQ-006 ISSUE SHALL hold newd=1 and dintx stable for exactly NEWD_HOLD cycles, then drive newd=0 and enter WAIT_DONE.
REQ-007 donetx SHALL pass through a 2-flop synchronizer. Only a synchronized rising edge SHALL count as completion; a level held high from a previous byte SHALL be ignored.
REQ-008 On completion in WAIT_DONE: ack[gnt_id]=1 for exactly one cycle, last_gnt=gnt_id, state to IDLE.
REQ-009 At most one ack bit SHALL be high in any cycle, and ack SHALL never be high outside the completion cycle.
REQ-010 A requester SHALL keep req and its din stable until ack. Deasserting req after grant SHALL NOT abort the transfer; ack is still pulsed.
REQ-011 req rising in the ack cycle SHALL be arbitrated on the next IDLE cycle, with the just-served requester lowest priority.
REQ-012 A donetx edge in IDLE or ISSUE SHALL be ignored.
REQ-013 dintx SHALL hold its last value while IDLE.

Reset
REQ-014 rst=0 at posedge clk SHALL force: state IDLE, newd=0, dintx=8'h00, ack=0, busy=0, gnt_id=0, timeout_err=0, last_gnt=NREQ-1 (so requester 0 is first), all counters=0, synchronizer flops=0.
REQ-015 Reset in ISSUE or WAIT_DONE SHALL abort the transfer with no ack pulse.

Configuration
REQ-016 Macro UART_ARB_TIMEOUT_EN defined: a WAIT_DONE counter SHALL run. When it reaches TIMEOUT with no completion, timeout_err SHALL pulse one cycle, no ack SHALL pulse, last_gnt=gnt_id, and state goes to IDLE.
REQ-017 Macro not defined: WAIT_DONE SHALL wait indefinitely, timeout_err SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-018 Single request: req=4'b0010, din[15:8]=8'hA5, donetx edge 10 cycles after newd falls -> newd high 128 cycles, dintx=8'hA5, ack=4'b0010 for one cycle, gnt_id=1.
REQ-019 Fairness: req=4'b1111 held, four completions after reset -> ack order 0,1,2,3 then 0; no requester served twice in a row while others request.
REQ-020 Stale done: donetx held high before the grant and still high in WAIT_DONE -> no ack until donetx falls and rises again.
REQ-021 Reset mid-transfer: rst=0 during WAIT_DONE -> next cycle busy=0, newd=0, no ack; the next grant goes to requester 0 if it requests.
REQ-022 Timeout with UART_ARB_TIMEOUT_EN and TIMEOUT=16, donetx stuck 0 -> timeout_err pulses 16 cycles after WAIT_DONE entry, ack=0, next requester granted. Without the macro -> busy stays 1 and timeout_err stays 0.
